// File: rtl/demux_m_pkg.sv
// demux_m_pkg: shared constants and types for the demux_m_stream slice.
//   DEPTH    default entries per channel FIFO
//   PTR_W    FIFO pointer width for the default depth
//   CH_A/B   in_s encoding (1 -> channel A, 0 -> channel B)
//   cnt_t    FIFO occupancy type (0..DEPTH needs PTR_W+1 bits)
//   ptr_width() pointer width for an arbitrary power-of-two depth
package demux_m_pkg;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic CH_A = 1'b1;
  localparam logic CH_B = 1'b0;

  typedef logic [PTR_W:0] cnt_t;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/demux_m_fifo.sv
// demux_m_fifo: per-channel synchronous FIFO with registered storage.
//   clk, rst_n    clock, asynchronous active-low reset (clears storage too)
//   push, push_data  write request and word (ignored when full)
//   pop           read request (ignored when empty)
//   full, empty   occupancy flags
//   head_data     oldest stored word; 0 after reset
module demux_m_fifo
  import demux_m_pkg::*;
#(
  parameter int M     = 4,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic [M:0] push_data,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [M:0] head_data
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [M:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign full      = (r_count == FULL_CNT);
  assign empty     = (r_count == '0);
  assign head_data = r_mem[r_rd_ptr];

  // Push is refused when full even if a pop happens the same cycle.
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/demux_m_stream.sv
// demux_m_stream: streaming 1-to-2 demultiplexer with per-channel FIFOs.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     input handshake; in_ready = selected channel not full
//   in_data, in_s         word and route select (1 -> A, 0 -> B)
//   a_valid/a_ready/a_data  channel A output stream
//   b_valid/b_ready/b_data  channel B output stream
// Optional (macro DEMUX_M_STREAM_STATS_EN):
//   a_count, b_count      saturating accepted-word counters
//   stall_seen            sticky: in_valid seen while in_ready low
module demux_m_stream
  import demux_m_pkg::*;
#(
  parameter int M     = 4,
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [M:0] in_data,
  input  logic       in_s,
  output logic       a_valid,
  input  logic       a_ready,
  output logic [M:0] a_data,
  output logic       b_valid,
  input  logic       b_ready,
  output logic [M:0] b_data
`ifdef DEMUX_M_STREAM_STATS_EN
  ,
  output logic [15:0] a_count,
  output logic [15:0] b_count,
  output logic        stall_seen
`endif
);

  logic w_a_full, w_a_empty, w_b_full, w_b_empty;
  logic w_accept, w_push_a, w_push_b;

  assign in_ready = (in_s == CH_A) ? ~w_a_full : ~w_b_full;
  assign w_accept = in_valid & in_ready;
  assign w_push_a = w_accept & (in_s == CH_A);
  assign w_push_b = w_accept & (in_s == CH_B);

  assign a_valid = ~w_a_empty;
  assign b_valid = ~w_b_empty;

  demux_m_fifo #(.M(M), .DEPTH(DEPTH)) u_fifo_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push_a),
    .push_data (in_data),
    .pop       (a_ready),
    .full      (w_a_full),
    .empty     (w_a_empty),
    .head_data (a_data)
  );

  demux_m_fifo #(.M(M), .DEPTH(DEPTH)) u_fifo_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push_b),
    .push_data (in_data),
    .pop       (b_ready),
    .full      (w_b_full),
    .empty     (w_b_empty),
    .head_data (b_data)
  );

`ifdef DEMUX_M_STREAM_STATS_EN
  logic [15:0] r_a_count;
  logic [15:0] r_b_count;
  logic        r_stall_seen;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_count    <= '0;
      r_b_count    <= '0;
      r_stall_seen <= 1'b0;
    end else begin
      if (w_push_a && r_a_count != '1) r_a_count <= r_a_count + 16'd1;
      if (w_push_b && r_b_count != '1) r_b_count <= r_b_count + 16'd1;
      if (in_valid && !in_ready)       r_stall_seen <= 1'b1;
    end
  end

  assign a_count    = r_a_count;
  assign b_count    = r_b_count;
  assign stall_seen = r_stall_seen;
`endif

endmodule
